// File: rtl/complex_nr_pkg.sv
// Shared definitions for the complex multiplier / accumulator pair:
// default widths, field-slice helpers and the accumulator FSM encoding.
package complex_nr_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ACC_LEN    = 4;
  localparam int DEF_GUARD_BITS = 4;

  // Width of one signed product component coming out of the multiplier.
  function automatic int prod_width(input int data_width);
    return 2 * data_width;
  endfunction

  // Width of one accumulator component: product width plus guard bits.
  function automatic int acc_width(input int data_width, input int guard_bits);
    return 2 * data_width + guard_bits;
  endfunction

  // Real field occupies the upper half of a packed complex word; imag the lower.
  function automatic int re_lsb(input int comp_width);
    return comp_width;
  endfunction

  function automatic int re_msb(input int comp_width);
    return 2 * comp_width - 1;
  endfunction

  function automatic int im_msb(input int comp_width);
    return comp_width - 1;
  endfunction

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } acc_state_e;

endpackage

// File: rtl/complex_nr_acc_lane.sv
// One accumulator lane: sign-extends a product component, adds it to the
// running sum and clears when the sum is handed off.
module complex_nr_acc_lane #(
  parameter int IN_W = 16,
  parameter int AW   = 20
) (
  input  logic            clk,
  input  logic            sw_rst,
  input  logic            add_en,
  input  logic            clear,
  input  logic [IN_W-1:0] sample,
  output logic [AW-1:0]   sum
);

  logic [AW-1:0] acc_q;
  logic [AW-1:0] acc_d;
  logic [AW-1:0] sample_ext;

  // Running sum including this cycle's sample; cleared when the sum closes.
  always_comb begin
    sample_ext = {{(AW-IN_W){sample[IN_W-1]}}, sample};
    sum        = acc_q + (add_en ? sample_ext : '0);
    acc_d      = clear ? '0 : sum;
  end

  // Accumulator register with synchronous reset.
  always_ff @(posedge clk) begin
    if (sw_rst) acc_q <= '0;
    else        acc_q <= acc_d;
  end

endmodule

// File: rtl/complex_nr_acc.sv
// Complex product accumulator: sums ACC_LEN products (or fewer on flush)
// and presents each finished sum on a valid/ready output.
module complex_nr_acc
  import complex_nr_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACC_LEN    = DEF_ACC_LEN,
  parameter int GUARD_BITS = DEF_GUARD_BITS,
  localparam int PW = prod_width(DATA_WIDTH),
  localparam int AW = acc_width(DATA_WIDTH, GUARD_BITS),
  localparam int CW = $clog2(ACC_LEN + 1)
) (
  input  logic              clk,
  input  logic              sw_rst,
  input  logic              in_val,
  output logic              in_ready,
  input  logic [2*PW-1:0]   in_data,
  input  logic              flush,
  output logic              out_val,
  input  logic              out_ready,
  output logic [2*AW-1:0]   out_data,
  output logic [CW-1:0]     out_cnt
);

  acc_state_e state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            out_val_q, out_val_d;
  logic [2*AW-1:0] out_data_q, out_data_d;
  logic [CW-1:0]   out_cnt_q, out_cnt_d;

  logic          fire;
  logic          close_sum;
  logic [AW-1:0] sum_re;
  logic [AW-1:0] sum_im;

  // Ready is purely a function of state and downstream ready (low in reset).
  assign in_ready = !sw_rst && ((state_q == ST_ACCUM) || out_ready);
  assign fire     = in_val && in_ready;

  complex_nr_acc_lane #(.IN_W(PW), .AW(AW)) u_lane_re (
    .clk    (clk),
    .sw_rst (sw_rst),
    .add_en (fire),
    .clear  (close_sum),
    .sample (in_data[re_msb(PW):re_lsb(PW)]),
    .sum    (sum_re)
  );

  complex_nr_acc_lane #(.IN_W(PW), .AW(AW)) u_lane_im (
    .clk    (clk),
    .sw_rst (sw_rst),
    .add_en (fire),
    .clear  (close_sum),
    .sample (in_data[im_msb(PW):0]),
    .sum    (sum_im)
  );

  // Next-state logic: decide whether the sum closes and update count/output.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    out_val_d  = out_val_q;
    out_data_d = out_data_q;
    out_cnt_d  = out_cnt_q;

    close_sum = (fire && (cnt_q == CW'(ACC_LEN - 1))) ||
                ((state_q == ST_ACCUM) && flush && ((cnt_q != '0) || fire));

    if (close_sum) begin
      cnt_d      = '0;
      out_val_d  = 1'b1;
      out_data_d = {sum_re, sum_im};
      out_cnt_d  = fire ? cnt_q + CW'(1) : cnt_q;
      state_d    = ST_HOLD;
    end else begin
      if (fire) cnt_d = cnt_q + CW'(1);
      if ((state_q == ST_HOLD) && out_ready) begin
        out_val_d = 1'b0;
        state_d   = ST_ACCUM;
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (sw_rst) begin
      state_q    <= ST_ACCUM;
      cnt_q      <= '0;
      out_val_q  <= 1'b0;
      out_data_q <= '0;
      out_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      out_val_q  <= out_val_d;
      out_data_q <= out_data_d;
      out_cnt_q  <= out_cnt_d;
    end
  end

  assign out_val  = out_val_q;
  assign out_data = out_data_q;
  assign out_cnt  = out_cnt_q;

endmodule

// File: tb/tb_complex_nr_acc.sv
// Scoreboard bench for complex_nr_acc: a list-based reference model pushes
// expected sums, a negedge monitor compares whatever the DUT presents.
module tb_complex_nr_acc;
  import complex_nr_pkg::*;

  localparam int DW = 8;
  localparam int AL = 4;
  localparam int GB = 4;
  localparam int PW = prod_width(DW);
  localparam int AW = acc_width(DW, GB);
  localparam int CW = $clog2(AL + 1);

  logic            clk;
  logic            sw_rst;
  logic            in_val;
  logic            in_ready;
  logic [2*PW-1:0] in_data;
  logic            flush;
  logic            out_val;
  logic            out_ready;
  logic [2*AW-1:0] out_data;
  logic [CW-1:0]   out_cnt;

  complex_nr_acc #(.DATA_WIDTH(DW), .ACC_LEN(AL), .GUARD_BITS(GB)) dut (
    .clk       (clk),
    .sw_rst    (sw_rst),
    .in_val    (in_val),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .flush     (flush),
    .out_val   (out_val),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_cnt   (out_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int re;
    int im;
    int n;
  } sum_t;

  sum_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   grp_re = 0;
  int   grp_im = 0;
  int   grp_n = 0;
  bit   pending = 1'b0;
  bit   exp_vis = 1'b0;
  bit   mon_en = 1'b0;
  int   accepted_cnt = 0;

  task automatic checkOutput(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs and advance the reference model for that edge.
  task automatic applyStimulus(input bit v, input int re, input int im,
                               input bit fl, input bit ordy, input bit rst);
    bit ready;
    bit in_accum;
    logic [PW-1:0] re_bits;
    logic [PW-1:0] im_bits;
    sum_t s;
    @(posedge clk);
    #1;
    re_bits   = re[PW-1:0];
    im_bits   = im[PW-1:0];
    in_val    = v;
    in_data   = {re_bits, im_bits};
    flush     = fl;
    out_ready = ordy;
    sw_rst    = rst;
    exp_vis   = pending;
    if (rst) begin
      if (pending && !ordy) void'(exp_q.pop_back());
      pending = 1'b0;
      grp_re = 0; grp_im = 0; grp_n = 0;
      ready = 1'b0;
    end else begin
      ready    = !pending || ordy;
      in_accum = !pending;
      if (pending && ordy) pending = 1'b0;
      if (v && ready) begin
        grp_re += re; grp_im += im; grp_n++;
        accepted_cnt++;
      end
      if ((grp_n == AL) || (in_accum && fl && grp_n > 0)) begin
        s.re = grp_re; s.im = grp_im; s.n = grp_n;
        exp_q.push_back(s);
        pending = 1'b1;
        grp_re = 0; grp_im = 0; grp_n = 0;
      end
    end
    #1;
    checkOutput("in_ready", in_ready, ready);
    mon_en = 1'b1;
  endtask

  // Monitor: compare the presented sum against the scoreboard head each cycle.
  always @(negedge clk) begin
    logic signed [AW-1:0] re_act;
    logic signed [AW-1:0] im_act;
    if (mon_en) begin
      checkOutput("out_val", out_val, exp_vis);
      if (out_val) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL spurious_sum: got out_val=1 expected no pending sum at %0t", $time);
        end else begin
          re_act = out_data[2*AW-1:AW];
          im_act = out_data[AW-1:0];
          checkOutput("sum_re", re_act, exp_q[0].re);
          checkOutput("sum_im", im_act, exp_q[0].im);
          checkOutput("out_cnt", out_cnt, exp_q[0].n);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    int cyc;
    sw_rst = 1'b1; in_val = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;

    // Reset and reset values
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("rst_out_val", out_val, 0);
    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_out_cnt", out_cnt, 0);

    // Basic sum -> (6,12)
    applyStimulus(1, 1, 2, 0, 1, 0);
    applyStimulus(1, 3, -4, 0, 1, 0);
    applyStimulus(1, -5, 6, 0, 1, 0);
    applyStimulus(1, 7, 8, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 1, 0);

    // Corner values and zeros
    for (int i = 0; i < 4; i++) applyStimulus(1, -32768, 32767, 0, 1, 0);
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 1, 0);

    // Backpressure: sum stalls 5 cycles, then handover with (2,2)
    for (int i = 0; i < 4; i++) applyStimulus(1, 3, -3, 0, 0, 0);
    for (int i = 0; i < 5; i++) applyStimulus(1, 9, 9, 0, 0, 0);
    applyStimulus(1, 2, 2, 0, 1, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 1, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 1, 0);

    // Flush: partial sum, idle flush, flush with first sample
    applyStimulus(1, 10, -10, 0, 1, 0);
    applyStimulus(1, 5, 5, 0, 1, 0);
    applyStimulus(0, 0, 0, 1, 1, 0);
    applyStimulus(0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 1, 1, 0);
    applyStimulus(0, 0, 0, 0, 1, 0);
    applyStimulus(1, 4, 4, 1, 1, 0);
    applyStimulus(0, 0, 0, 0, 1, 0);

    // Reset mid-accumulation discards the partial sum
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 1, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 4; i++) applyStimulus(1, 2, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 1, 0);

    // Random traffic
    accepted_cnt = 0;
    cyc = 0;
    while (accepted_cnt < 1000 && cyc < 20000) begin
      applyStimulus($urandom_range(0, 3) != 0,
                    int'($urandom_range(0, 65535)) - 32768,
                    int'($urandom_range(0, 65535)) - 32768,
                    $urandom_range(0, 9) == 0,
                    $urandom_range(0, 9) < 7, 0);
      cyc++;
    end
    checkOutput("random_accepted", accepted_cnt >= 1000, 1);

    // Drain whatever is left
    applyStimulus(0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 0, 1, 0);
    checkOutput("scoreboard_empty", exp_q.size(), 0);

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/complex_nr_acc.md
# complex_nr_acc

Complex product accumulator placed directly downstream of the complex number multiplier. Consumes the multiplier's result stream (`res_val`/`res_ready`/`res_data`), sums ACC_LEN consecutive complex products (real and imaginary independently, full precision with guard bits) and presents each completed sum on a valid/ready output. An early `flush` closes a partial sum, which supports dot-product and correlation runs shorter than ACC_LEN.

## Interface
- `DATA_WIDTH`, 8: operand width of the upstream multiplier; each product component is 2*DATA_WIDTH signed.
- `ACC_LEN`, 4: products per sum; legal range 1 to 2^GUARD_BITS.
- `GUARD_BITS`, 4: extra accumulator MSBs. Accumulator component width AW = 2*DATA_WIDTH+GUARD_BITS.
- Clocking and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  rising-edge clock.
- `sw_rst`  in  1  synchronous active-high reset.
- `in_val`  in  1  product valid; driven by multiplier `res_val`.
- `in_ready`  out  1  accumulator accepts product; drives multiplier `res_ready`.
- `in_data`  in  4*DATA_WIDTH  product. [4*DATA_WIDTH-1:2*DATA_WIDTH] is signed real; [2*DATA_WIDTH-1:0] is signed imag.
- `flush`  in  1  close the current partial sum. Level-sampled each cycle.
- `out_val`  out  1  sum valid.
- `out_ready`  in  1  downstream accepts sum.
- `out_data`  out  2*AW  sum. [2*AW-1:AW] is real; [AW-1:0] is imag; both two's complement.
- `out_cnt`  out  $clog2(ACC_LEN+1)  number of products in `out_data`.

## Operation
- Two-state FSM with states ACCUM and HOLD. Internal registers: `acc_re`, `acc_im` (AW bits each) and `cnt`.
- Input components are sign-extended to AW bits. There is no saturation. Overflow cannot occur within the legal ACC_LEN range.
- In ACCUM:
  - `in_ready` is 1.
  - A product is accepted when `in_val && in_ready`. On acceptance: `acc += sample` and `cnt++`.
  - Close condition: acceptance with `cnt == ACC_LEN-1`, or `flush` with (`cnt > 0` or acceptance in the same cycle).
  - On close: register `out_data` = acc plus the sample accepted that cycle (if any), register `out_cnt`, set `out_val`, clear `acc` and `cnt`, and go to HOLD.
  - `flush` with `cnt == 0` and no acceptance is ignored.
  - When `flush` and an acceptance occur in the same cycle, the sample is included in the closed sum.
- In HOLD:
  - `out_data` and `out_cnt` are held stable while `out_val && !out_ready`.
  - `in_ready` = `out_ready`. This gives zero-bubble handover.
  - On `out_ready`: `out_val` drops and the FSM returns to ACCUM. A product accepted in the same cycle loads into `acc` with `cnt = 1`. If ACC_LEN == 1, that product instead closes immediately and the FSM stays in HOLD with the new sum.
  - `flush` is ignored in HOLD.
- `sw_rst` has priority over all other inputs. Reset mid-accumulation or mid-hold discards the partial or pending sum.

## Timing
- Reset values: `out_val` 0, `out_data` 0, `out_cnt` 0, `in_ready` 0 during the reset cycle and 1 from the first cycle after reset, `acc` 0, `cnt` 0, FSM state ACCUM.
- Latency: the closing sample or `flush` at edge k gives `out_val` = 1 after edge k, so the sum is visible in cycle k+1.
- Throughput: one product per cycle sustained when `out_ready` is held high. There are no bubbles between sums.
- `in_ready` is combinational from state and `out_ready` only. It never depends on `in_val`.
- All outputs except `in_ready` are registered.

## Structure
- Shared package/header `complex_nr_pkg`:
  - DATA_WIDTH-derived widths (product width, AW).
  - Real/imag field slice constants for `in_data` and `out_data`.
  - FSM state encodings.
  - The multiplier uses the same slice constants.
- Sub-module `complex_nr_acc_lane` holds one signed sign-extend/add/clear register. It is instantiated twice, once for real and once for imag. The FSM and counter live in the top module.

## Test plan
Default parameters (DATA_WIDTH 8, ACC_LEN 4, GUARD_BITS 4) throughout. A reference model runs in parallel to the directed tests.
- **Basic sum:** stream (1,2),(3,-4),(-5,6),(7,8) back-to-back with `out_ready` = 1 -> one `out_val` pulse the cycle after the 4th acceptance, `out_data` = (6,12), `out_cnt` = 4.
- **Corner values:** four products of (-32768,32767) -> (-131072,131068), correctly sign-extended in 20 bits. Also check four products of (0,0) -> (0,0).
- **Backpressure and handover:**
  - Hold `out_ready` = 0 for 5 cycles after a sum -> `out_data` stable and `in_ready` = 0.
  - Then `out_ready` = 1 with `in_val` = 1 carrying (2,2) in the same cycle -> sample accepted.
  - Next sum of (2,2)+(1,1)x3 = (5,5).
- **Flush:**
  - (10,-10),(5,5) then `flush` -> (15,-5) with `out_cnt` = 2.
  - `flush` on an idle accumulator -> no output.
  - `flush` together with the 1st sample (4,4) -> (4,4) with `out_cnt` = 1.
- **Reset mid-operation:**
  - 3 samples of (1,1), then `sw_rst` for 1 cycle -> `out_val` stays 0.
  - The next 4 samples of (2,0) -> (8,0) with `out_cnt` = 4.
- **Random:** 1000 random products with random `in_val`/`out_ready`/`flush`, compared against the model -> zero mismatches and no lost or duplicated sums.
